// File: rtl/sad_pkg.sv
//------------------------------------------------------------------------------
// Module      : sad_pkg
// Description : Shared types and sizing helpers for the multi-lane SAD engine.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package sad_pkg;

  // Block controller states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } sad_state_e;

  // Number of input beats that make up one block
  function automatic int sad_beats(input int block_len, input int lanes);
    return block_len / lanes;
  endfunction

  // Width of the per-beat adder tree result
  function automatic int sad_tree_w(input int data_w, input int lanes);
    return data_w + $clog2(lanes);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sad_multi_if.sv
//------------------------------------------------------------------------------
// Module      : sad_multi_if
// Description : Sample stream, control and result bundle of the SAD engine.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface sad_multi_if #(
  parameter int DATA_W = 8,
  parameter int LANES  = 4,
  parameter int OUT_W  = 32,
  parameter int IDX_W  = 8
);
  logic                      start_i;
  logic                      clear_best_i;
  logic                      valid_i;
  logic                      ready_o;
  logic [LANES*DATA_W-1:0]   dta_i;
  logic [LANES*DATA_W-1:0]   dtb_i;
  logic                      busy_o;
  logic                      done_o;
  logic [OUT_W-1:0]          dt_o;
  logic [OUT_W-1:0]          best_o;
  logic [IDX_W-1:0]          best_idx_o;

  // Pixel fetch side: drives samples and control, observes results
  modport master (
    output start_i, clear_best_i, valid_i, dta_i, dtb_i,
    input  ready_o, busy_o, done_o, dt_o, best_o, best_idx_o
  );

  // SAD engine side
  modport slave (
    input  start_i, clear_best_i, valid_i, dta_i, dtb_i,
    output ready_o, busy_o, done_o, dt_o, best_o, best_idx_o
  );
endinterface

`default_nettype wire

// File: rtl/sad_absdiff_tree.sv
//------------------------------------------------------------------------------
// Module      : sad_absdiff_tree
// Description : Per-lane absolute differences and a balanced adder tree that
//               reduces a (registered) vector of differences to one sum.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sad_absdiff_tree
  import sad_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int LANES  = 4
) (
  input  logic [LANES*DATA_W-1:0]            a,
  input  logic [LANES*DATA_W-1:0]            b,
  output logic [LANES*DATA_W-1:0]            diff,
  input  logic [LANES*DATA_W-1:0]            diff_q,
  output logic [DATA_W+$clog2(LANES)-1:0]    sum
);

  localparam int TREE_W = sad_tree_w(DATA_W, LANES);

  // Compare-then-subtract keeps every difference inside DATA_W bits
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [DATA_W-1:0] a_k;
    logic [DATA_W-1:0] b_k;
    assign a_k = a[k*DATA_W +: DATA_W];
    assign b_k = b[k*DATA_W +: DATA_W];
    assign diff[k*DATA_W +: DATA_W] = (a_k >= b_k) ? (a_k - b_k) : (b_k - a_k);
  end

  logic [TREE_W-1:0] node [LANES];

  // Pairwise reduction: each pass halves the live nodes, giving log2(LANES) levels
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      node[i] = TREE_W'(diff_q[i*DATA_W +: DATA_W]);
    end
    for (int step = 1; step < LANES; step = step * 2) begin
      for (int i = 0; i < LANES; i = i + 2 * step) begin
        node[i] = node[i] + node[i+step];
      end
    end
    sum = node[0];
  end

endmodule

`default_nettype wire

// File: rtl/sad_multi.sv
//------------------------------------------------------------------------------
// Module      : sad_multi
// Description : Multi-lane sum-of-absolute-differences engine with a two-stage
//               pipeline and minimum-SAD tracking across consecutive blocks.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sad_multi
  import sad_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int LANES     = 4,
  parameter int BLOCK_LEN = 256,
  parameter int OUT_W     = 32,
  parameter int IDX_W     = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  sad_multi_if.slave   bus
);

  localparam int BEATS  = sad_beats(BLOCK_LEN, LANES);
  localparam int TREE_W = sad_tree_w(DATA_W, LANES);
  localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic [OUT_W-1:0] ALL_ONES  = '1;

  if (OUT_W < DATA_W + $clog2(BLOCK_LEN)) begin : g_chk_out_w
    $error("sad_multi: OUT_W too narrow for DATA_W and BLOCK_LEN");
  end
  if (LANES < 1 || (LANES & (LANES - 1)) != 0) begin : g_chk_lanes
    $error("sad_multi: LANES must be a power of two");
  end
  if (BLOCK_LEN % LANES != 0) begin : g_chk_block
    $error("sad_multi: BLOCK_LEN must be a multiple of LANES");
  end

  sad_state_e              state;
  logic [CNT_W-1:0]        beat_cnt;
  logic                    drain_cnt;
  logic                    ready;
  logic                    busy;
  logic                    done;
  logic                    accept;
  logic                    s1_valid;
  logic [LANES*DATA_W-1:0] s1_diff;
  logic [LANES*DATA_W-1:0] diff;
  logic [TREE_W-1:0]       tree_sum;
  logic [OUT_W-1:0]        acc;
  logic [OUT_W-1:0]        dt;
  logic [OUT_W-1:0]        best;
  logic [IDX_W-1:0]        best_idx;
  logic [IDX_W-1:0]        blk_idx;
  logic                    first_blk;

  assign accept = bus.valid_i && ready;

  sad_absdiff_tree #(
    .DATA_W (DATA_W),
    .LANES  (LANES)
  ) u_tree (
    .a      (bus.dta_i),
    .b      (bus.dtb_i),
    .diff   (diff),
    .diff_q (s1_diff),
    .sum    (tree_sum)
  );

  // Block controller with registered handshake/status outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      ready     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      beat_cnt  <= '0;
      drain_cnt <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start_i) begin
            state    <= ACCUM;
            ready    <= 1'b1;
            busy     <= 1'b1;
            beat_cnt <= '0;
          end
        end
        ACCUM: begin
          if (accept) begin
            if (beat_cnt == LAST_BEAT) begin
              state     <= DRAIN;
              ready     <= 1'b0;
              beat_cnt  <= '0;
              drain_cnt <= 1'b0;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        DRAIN: begin
          // Two cycles: one for the diff register, one for the accumulator
          if (drain_cnt) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            drain_cnt <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Stage 1 captures lane differences, stage 2 folds the tree sum into acc
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid <= 1'b0;
      s1_diff  <= '0;
      acc      <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_diff <= diff;
      end
      if (state == IDLE && bus.start_i) begin
        acc <= '0;
      end else if (s1_valid) begin
        acc <= acc + OUT_W'(tree_sum);
      end
    end
  end

  // Result capture and minimum tracking; a clear in DONE still records the block
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dt        <= '0;
      best      <= ALL_ONES;
      best_idx  <= '0;
      blk_idx   <= '0;
      first_blk <= 1'b1;
    end else begin
      if (state == DRAIN && drain_cnt) begin
        dt <= acc;
      end
      if (state == DONE) begin
        if (bus.clear_best_i) begin
          best      <= dt;
          best_idx  <= '0;
          blk_idx   <= IDX_W'(1);
          first_blk <= 1'b0;
        end else begin
          if (first_blk || dt < best) begin
            best     <= dt;
            best_idx <= blk_idx;
          end
          blk_idx   <= blk_idx + 1'b1;
          first_blk <= 1'b0;
        end
      end else if (bus.clear_best_i) begin
        best      <= ALL_ONES;
        blk_idx   <= '0;
        first_blk <= 1'b1;
      end
    end
  end

  assign bus.ready_o    = ready;
  assign bus.busy_o     = busy;
  assign bus.done_o     = done;
  assign bus.dt_o       = dt;
  assign bus.best_o     = best;
  assign bus.best_idx_o = best_idx;

endmodule

`default_nettype wire

// File: tb/tb_sad_multi.sv
//------------------------------------------------------------------------------
// Module      : tb_sad_multi
// Description : Scoreboard bench for sad_multi (default build and a
//               single-lane, 255-pair build sharing clock and reset).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_sad_multi;

  localparam int DATA_W    = 8;
  localparam int LANES     = 4;
  localparam int BLOCK_LEN = 256;
  localparam int OUT_W     = 32;
  localparam int IDX_W     = 8;
  localparam int BEATS     = BLOCK_LEN / LANES;
  localparam int L1_LEN    = 255;
  localparam longint ALL_ONES = (64'd1 << OUT_W) - 1;

  typedef struct {
    longint dt;
    longint best;
    longint idx;
    longint done_cyc;
  } exp_t;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  longint cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sad_multi_if #(.DATA_W(DATA_W), .LANES(LANES), .OUT_W(OUT_W), .IDX_W(IDX_W)) bus ();
  sad_multi_if #(.DATA_W(DATA_W), .LANES(1), .OUT_W(OUT_W), .IDX_W(IDX_W)) bus1 ();

  sad_multi #(.DATA_W(DATA_W), .LANES(LANES), .BLOCK_LEN(BLOCK_LEN), .OUT_W(OUT_W), .IDX_W(IDX_W))
    dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  sad_multi #(.DATA_W(DATA_W), .LANES(1), .BLOCK_LEN(L1_LEN), .OUT_W(OUT_W), .IDX_W(IDX_W))
    dut1 (.clk_i(clk), .rst_i(rst), .bus(bus1));

  int     vectors = 0;
  int     errors  = 0;
  exp_t   q0[$];
  exp_t   q1[$];
  longint m_best [2];
  longint m_idx  [2];
  longint m_blk  [2];
  bit     m_first[2];
  int     blk_a  [256];
  int     blk_b  [256];

  task automatic check(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    vectors++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Reference model: best-so-far bookkeeping described directly in block terms
  function automatic void model_clear(input int d);
    m_best[d]  = ALL_ONES;
    m_idx[d]   = 0;
    m_blk[d]   = 0;
    m_first[d] = 1'b1;
  endfunction

  function automatic exp_t model_done(input int d, input longint sad, input bit clr, input longint dc);
    exp_t e;
    if (clr) begin
      m_best[d] = sad;
      m_idx[d]  = 0;
      m_blk[d]  = 1;
    end else begin
      if (m_first[d] || sad < m_best[d]) begin
        m_best[d] = sad;
        m_idx[d]  = m_blk[d];
      end
      m_blk[d] = (m_blk[d] + 1) % (64'd1 << IDX_W);
    end
    m_first[d] = 1'b0;
    e.dt       = sad;
    e.best     = m_best[d];
    e.idx      = m_idx[d];
    e.done_cyc = dc;
    return e;
  endfunction

  // mode 0: full scale, 1: random, 2: exact target SAD
  function automatic longint make_block(input int mode, input int n, input longint target);
    longint sad = 0;
    longint rem = target;
    int d, base;
    for (int p = 0; p < n; p++) begin
      case (mode)
        0: begin blk_a[p] = 255; blk_b[p] = 0; end
        1: begin blk_a[p] = int'($urandom_range(255)); blk_b[p] = int'($urandom_range(255)); end
        default: begin
          d    = (rem > 255) ? 255 : int'(rem);
          rem  = rem - d;
          base = int'($urandom_range(255 - d));
          if ($urandom_range(1) == 1) begin blk_a[p] = base + d; blk_b[p] = base; end
          else begin blk_a[p] = base; blk_b[p] = base + d; end
        end
      endcase
      sad += (blk_a[p] > blk_b[p]) ? (blk_a[p] - blk_b[p]) : (blk_b[p] - blk_a[p]);
    end
    return sad;
  endfunction

  task automatic reset_checks(input string tag);
    check({tag, " ready"},    longint'(bus.ready_o),    0);
    check({tag, " busy"},     longint'(bus.busy_o),     0);
    check({tag, " done"},     longint'(bus.done_o),     0);
    check({tag, " dt"},       longint'(bus.dt_o),       0);
    check({tag, " best"},     longint'(bus.best_o),     ALL_ONES);
    check({tag, " best_idx"}, longint'(bus.best_idx_o), 0);
  endtask

  task automatic run_block0(input int mode, input longint target, input int vprob,
                            input bit hold_start, input bit clr_done, input int abort_beat);
    longint sad;
    longint last_cyc = 0;
    int     beat = 0;
    int     guard = 0;
    exp_t   e;
    sad = make_block(mode, BLOCK_LEN, target);
    @(negedge clk);
    bus.start_i = 1'b1;
    while (beat < BEATS && guard < 4 * BEATS + 400) begin
      @(negedge clk);
      guard++;
      bus.start_i = hold_start;
      if (beat == abort_beat) begin
        rst = 1'b1; bus.valid_i = 1'b0; bus.start_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_clear(0);
        model_clear(1);
        reset_checks("abort");
        return;
      end
      bus.valid_i = ($urandom_range(99) < vprob);
      for (int k = 0; k < LANES; k++) begin
        bus.dta_i[k*DATA_W +: DATA_W] = DATA_W'(blk_a[beat*LANES+k]);
        bus.dtb_i[k*DATA_W +: DATA_W] = DATA_W'(blk_b[beat*LANES+k]);
      end
      if (bus.valid_i && bus.ready_o) begin
        last_cyc = cyc;
        beat++;
      end
    end
    if (beat < BEATS) begin
      flag("block0 accept timeout");
      bus.valid_i = 1'b0; bus.start_i = 1'b0;
      return;
    end
    @(negedge clk);
    bus.valid_i = 1'b0; bus.start_i = 1'b0;
    e = model_done(0, sad, clr_done, last_cyc + 3);
    q0.push_back(e);
    guard = 0;
    while (!bus.done_o && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.done_o) flag("block0 done timeout");
    else if (clr_done) bus.clear_best_i = 1'b1;
    @(negedge clk);
    bus.clear_best_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_block1(input int vprob);
    longint sad;
    longint last_cyc = 0;
    int     beat = 0;
    int     guard = 0;
    exp_t   e;
    sad = make_block(1, L1_LEN, 0);
    @(negedge clk);
    bus1.start_i = 1'b1;
    while (beat < L1_LEN && guard < 4 * L1_LEN + 400) begin
      @(negedge clk);
      guard++;
      bus1.start_i = 1'b0;
      bus1.valid_i = ($urandom_range(99) < vprob);
      bus1.dta_i   = DATA_W'(blk_a[beat]);
      bus1.dtb_i   = DATA_W'(blk_b[beat]);
      if (bus1.valid_i && bus1.ready_o) begin
        last_cyc = cyc;
        beat++;
      end
    end
    if (beat < L1_LEN) begin
      flag("block1 accept timeout");
      bus1.valid_i = 1'b0;
      return;
    end
    @(negedge clk);
    bus1.valid_i = 1'b0;
    e = model_done(1, sad, 1'b0, last_cyc + 3);
    q1.push_back(e);
    guard = 0;
    while (!bus1.done_o && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    if (!bus1.done_o) flag("block1 done timeout");
    repeat (2) @(negedge clk);
  endtask

  task automatic clear_idle();
    @(negedge clk);
    bus.clear_best_i = 1'b1;
    @(negedge clk);
    bus.clear_best_i = 1'b0;
    model_clear(0);
  endtask

  // Monitor for the default build: pops the scoreboard on every done pulse
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.done_o) begin
        if (q0.size() == 0) begin
          flag("dut unexpected done");
        end else begin
          e = q0.pop_front();
          check("dut dt", longint'(bus.dt_o), e.dt);
          check("dut done latency", cyc, e.done_cyc);
          @(negedge clk);
          check("dut done width", longint'(bus.done_o), 0);
          check("dut best", longint'(bus.best_o), e.best);
          check("dut best_idx", longint'(bus.best_idx_o), e.idx);
        end
      end
    end
  end

  // Monitor for the single-lane build
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus1.done_o) begin
        if (q1.size() == 0) begin
          flag("dut1 unexpected done");
        end else begin
          e = q1.pop_front();
          check("dut1 dt", longint'(bus1.dt_o), e.dt);
          check("dut1 done latency", cyc, e.done_cyc);
          @(negedge clk);
          check("dut1 done width", longint'(bus1.done_o), 0);
          check("dut1 best", longint'(bus1.best_o), e.best);
          check("dut1 best_idx", longint'(bus1.best_idx_o), e.idx);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start_i = 1'b0;  bus.clear_best_i = 1'b0;  bus.valid_i = 1'b0;
    bus.dta_i   = '0;    bus.dtb_i        = '0;
    bus1.start_i = 1'b0; bus1.clear_best_i = 1'b0; bus1.valid_i = 1'b0;
    bus1.dta_i   = '0;   bus1.dtb_i        = '0;
    model_clear(0);
    model_clear(1);

    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    reset_checks("reset");

    // Full-scale block, then a random block with stalls and start held high
    run_block0(0, 0, 100, 1'b0, 1'b0, -1);
    run_block0(1, 0, 50, 1'b1, 1'b0, -1);

    // Minimum tracking with a tie, then clear and a fresh candidate
    clear_idle();
    run_block0(2, 500, 80, 1'b0, 1'b0, -1);
    run_block0(2, 120, 80, 1'b0, 1'b0, -1);
    run_block0(2, 120, 80, 1'b0, 1'b0, -1);
    clear_idle();
    run_block0(2, 900, 80, 1'b0, 1'b0, -1);

    // Clear landing in the DONE cycle, followed by a smaller block
    run_block0(1, 0, 70, 1'b0, 1'b1, -1);
    run_block0(2, 1000, 70, 1'b0, 1'b0, -1);

    // Reset at beat 30 with start held during accumulation, then a fresh block
    run_block0(1, 0, 60, 1'b1, 1'b0, 30);
    repeat (3) @(negedge clk);
    run_block0(1, 0, 60, 1'b0, 1'b0, -1);

    // Single-lane, 255-pair build
    for (int n = 0; n < 12; n++) run_block1(70);

    repeat (5) @(negedge clk);
    if (q0.size() != 0) flag("dut scoreboard not drained");
    if (q1.size() != 0) flag("dut1 scoreboard not drained");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sad_multi.md
Name: sad_multi

Overview:
- Parametrised successor to the single-lane SAD engine.
- Accumulates the sum of absolute differences over a block of BLOCK_LEN sample pairs, taking LANES pairs per beat, with a valid/ready input handshake and a one-cycle done pulse.
- Tracks the minimum SAD, and the index of the block that produced it, across consecutive blocks for motion-estimation candidate search.
- Sits between the pixel fetch unit and the motion-vector selector.

Parameters:
- DATA_W, 8: bits per sample (unsigned).
- LANES, 4: sample pairs per input beat; power of two, at least 1.
- BLOCK_LEN, 256: sample pairs per block; a multiple of LANES.
- OUT_W, 32: result width. Elaboration fails unless OUT_W >= DATA_W + $clog2(BLOCK_LEN).
- IDX_W, 8: width of the block index counter.

Ports:
- clk_i, in, 1: clock. Design has one clock.
- rst_i, in, 1: reset, synchronous and active-high.
- start_i, in, 1: begin a new block. Honoured only in IDLE.
- clear_best_i, in, 1: reset minimum tracking and block index.
- valid_i, in, 1: dta_i/dtb_i beat valid.
- ready_o, out, 1: beat accepted when valid_i && ready_o.
- dta_i, in, LANES*DATA_W: lane k = bits [k*DATA_W +: DATA_W].
- dtb_i, in, LANES*DATA_W: same packing as dta_i.
- busy_o, out, 1: high in ACCUM and DRAIN.
- done_o, out, 1: one-cycle pulse; dt_o is valid from this cycle onward.
- dt_o, out, OUT_W: SAD of the last completed block.
- best_o, out, OUT_W: minimum SAD since the last clear.
- best_idx_o, out, IDX_W: index of the block that produced best_o.

Behaviour:
- Reset values (rst_i sampled high at an edge):
  - state=IDLE; ready_o=0, busy_o=0, done_o=0.
  - dt_o=0; best_o=all ones; best_idx_o=0.
  - Block index=0; beat counter=0; pipeline valid flags cleared.
- Reset mid-block aborts the block with no done_o pulse.
- FSM states: IDLE, ACCUM, DRAIN, DONE.
  - IDLE -> ACCUM on start_i. The accumulator is cleared on this edge.
  - ACCUM: ready_o=1. Each accepted beat increments the beat counter, which runs 0..BEATS-1 where BEATS = BLOCK_LEN/LANES. ACCUM -> DRAIN on acceptance of beat BEATS-1. valid_i low simply stalls; gaps are unbounded.
  - DRAIN: ready_o=0. Lasts until the pipeline is empty (2 cycles).
  - DONE: lasts one cycle. done_o=1, dt_o is updated, then -> IDLE.
- Pipeline:
  - Stage 1 registers LANES absolute differences, each DATA_W bits, computed as |a-b| without sign overflow.
  - Stage 2 adds the adder-tree sum, DATA_W+$clog2(LANES) bits, into the OUT_W accumulator.
- Latency: the last beat accepted at edge N gives done_o high and the new dt_o in the cycle after edge N+2.
- dt_o holds its value until the next DONE.
- start_i outside IDLE is ignored. start_i coincident with the DONE cycle is ignored; the start must be held or reissued in IDLE.
- Minimum tracking, applied in the DONE cycle:
  - If dt < best_o, or this is the first completed block since clear: best_o <= dt and best_idx_o <= block index.
  - The block index then increments and wraps at 2^IDX_W.
  - Ties keep the earlier index.
- clear_best_i:
  - Sets best_o = all ones and the block index to 0.
  - Does not disturb a block in progress.
  - If coincident with DONE, clear takes precedence: the completing block is recorded as best with best_idx_o = 0, and the index becomes 1.
- Accumulator never overflows given the OUT_W constraint. No saturation logic.

Decomposition:
- Package sad_pkg holds:
  - the sad_state_e enum (IDLE, ACCUM, DRAIN, DONE);
  - the localparam helper functions for BEATS and the tree sum width.
- Sub-module sad_absdiff_tree:
  - combinational LANES-wide abs-diff plus a balanced adder tree;
  - parametrised by DATA_W and LANES.
- The top level holds the FSM, counters, pipeline registers and min tracking.

Test Plan:
- Reset: hold rst_i 2 cycles, then check ready_o=0, busy_o=0, done_o=0, dt_o=0, best_o=32'hFFFFFFFF, best_idx_o=0.
- Full-scale block: defaults, all a=255, b=0, continuous valid_i. Expect done_o exactly 3 cycles after the 64th beat and dt_o=65280, best_o=65280, best_idx_o=0.
- Random block with valid_i gaps: random valid_i at 50% against a scoreboard of sum|a-b| over 256 pairs. Expect dt_o to match and done_o to pulse exactly once.
- Min tracking: three blocks with SAD 500, 120, 120. Expect best_o=120, best_idx_o=1 (tie keeps the earlier index). Then clear_best_i plus a block with SAD 900 gives best_o=900, best_idx_o=0.
- start_i asserted during ACCUM, and rst_i asserted at beat 30. Expect the start to be ignored, no done_o, and IDLE with reset values next cycle. A fresh block then gives the correct SAD.
- LANES=1, BLOCK_LEN=255 build, mirroring the legacy engine: 1000 random seeds, all results matching the scoreboard.
